// File: rtl/result_accumulator.sv
// Groups ACC_COUNT consecutive result beats into one widened total over valid/ready.
// Optional early group close via flush_i when ACC_FLUSH_EN is defined.
module result_accumulator #(
   parameter int unsigned DATA_IN_WIDTH = 8,
   parameter int unsigned ACC_COUNT     = 4,
   parameter int unsigned ACC_WIDTH     = DATA_IN_WIDTH + $clog2(ACC_COUNT)
) (
   input  logic                               clk_i,
   input  logic                               srst,
   input  logic [DATA_IN_WIDTH-1:0]           in,
   input  logic                               in_valid,
   output logic                               in_ready,
`ifdef ACC_FLUSH_EN
   input  logic                               flush_i,
`endif
   output logic [ACC_WIDTH-1:0]               out,
   output logic [$clog2(ACC_COUNT+1)-1:0]     out_count,
   output logic                               out_valid,
   input  logic                               out_ready
);

   localparam int unsigned CNT_W = $clog2(ACC_COUNT + 1);

   if (ACC_COUNT < 2 || ACC_COUNT > 256) begin : g_bad_count
      $error("result_accumulator: ACC_COUNT must be in 2..256");
   end
   if (ACC_WIDTH < DATA_IN_WIDTH + $clog2(ACC_COUNT)) begin : g_bad_width
      $error("result_accumulator: ACC_WIDTH too narrow for ACC_COUNT beats");
   end

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0]     out_count_q, out_count_d;
   logic                 out_valid_q, out_valid_d;
   logic                 in_ready_q, in_ready_d;

   logic                 flush_c;
   logic                 accept_c;
   logic                 close_c;
   logic [ACC_WIDTH-1:0] sum_c;
   logic [CNT_W-1:0]     cnt_inc_c;

`ifdef ACC_FLUSH_EN
   assign flush_c = flush_i;
`else
   assign flush_c = 1'b0;
`endif

   // in_ready_q is only high in ACCUM, so it doubles as the accept qualifier
   assign accept_c  = in_valid && in_ready_q;
   assign sum_c     = acc_q + ACC_WIDTH'(in);
   assign cnt_inc_c = cnt_q + CNT_W'(1);
   assign close_c   = (accept_c && (cnt_inc_c == CNT_W'(ACC_COUNT)))
                   || (in_ready_q && flush_c && (accept_c || (cnt_q != '0)));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;

      case (state_q)
         ACCUM: begin
            in_ready_d = 1'b1;
            if (accept_c) begin
               acc_d = sum_c;
               cnt_d = cnt_inc_c;
            end
            if (close_c) begin
               out_d       = accept_c ? sum_c : acc_q;
               out_count_d = accept_c ? cnt_inc_c : cnt_q;
               acc_d       = '0;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               in_ready_d  = 1'b0;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out       = out_q;
   assign out_count = out_count_q;
   assign out_valid = out_valid_q;

endmodule
